task_cfg_monitor: RTL and testbench

Synthesizable runtime monitor for NUM_CH task engines, such as packet builders and parsers, in the packet-processing top. It replaces the fixed two-builder, single-parser start-time config checks with a parametrised block.

---
 rtl/task_mon_pkg.sv | 27 ++
 rtl/task_ch_mon.sv | 135 +++++++++++++
 rtl/task_cfg_monitor.sv | 50 +++++
 tb/tb_task_cfg_monitor.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_mon_pkg.sv
// Shared types for the task config monitor: channel FSM states and the packet-builder config layout.
package task_mon_pkg;

  localparam int unsigned PB_CFG_W = 96;

  typedef enum logic [0:0] {
    MON_IDLE,
    MON_ACTIVE
  } mon_state_e;

  // The first field is the MSB of the packed word.
  typedef struct packed {
    logic [31:0] addr_in;
    logic [3:0]  byte_cnt;
    logic [3:0]  pkt_type;
    logic        ecc_en;
    logic        crc_en;
    logic [1:0]  ins_ecc_err;
    logic        ins_crc_err;
    logic [3:0]  ecc_val;
    logic [7:0]  crc_val;
    logic [2:0]  sop_val;
    logic [3:0]  data_sel;
    logic [31:0] addr_out;
  } pb_cfg_t;

endpackage

// File: rtl/task_ch_mon.sv
// One monitored task channel: start/irq lifecycle FSM, config snapshot, sticky flags and counter.
// The active-cycle timeout timer is built only when TASK_MON_TIMEOUT_EN is defined.
module task_ch_mon
  import task_mon_pkg::*;
#(
  parameter int unsigned CFG_W       = PB_CFG_W,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CFG_W-1:0] exp_cfg_i,
  input  logic [CFG_W-1:0] ch_cfg_i,
  input  logic             start_i,
  input  logic             irq_i,
  input  logic             err_clr_i,
  output logic             err_cfg_o,
  output logic             err_proto_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] done_cnt_o,
  output logic             active_o
);

  mon_state_e       state_q, state_d;
  logic [CFG_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_cfg_q, err_cfg_d;
  logic             err_proto_q, err_proto_d;
  logic             exp_miss, snap_miss;
  logic [CNT_W-1:0] cnt_inc;

  assign exp_miss  = (ch_cfg_i != exp_cfg_i);
  assign snap_miss = (ch_cfg_i != snap_q);
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MON_IDLE;
      snap_q      <= '0;
      cnt_q       <= '0;
      err_cfg_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      err_cfg_q   <= err_cfg_d;
      err_proto_q <= err_proto_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    // Clear first so that a new error in the same cycle wins over err_clr_i.
    err_cfg_d   = err_cfg_q & ~err_clr_i;
    err_proto_d = err_proto_q & ~err_clr_i;

    case (state_q)
      MON_IDLE: begin
        if (irq_i) begin
          err_proto_d = 1'b1;
        end
      end
      MON_ACTIVE: begin
        if (!start_i && snap_miss) begin
          err_cfg_d = 1'b1;
        end
        if (irq_i) begin
          cnt_d = cnt_inc;
        end
        if (start_i && !irq_i) begin
          err_proto_d = 1'b1;
        end
        if (irq_i && !start_i) begin
          state_d = MON_IDLE;
        end
      end
      default: state_d = MON_IDLE;
    endcase

    // Every start, whatever the state, launches a fresh task.
    if (start_i) begin
      if (exp_miss) begin
        err_cfg_d = 1'b1;
      end
      snap_d  = ch_cfg_i;
      state_d = MON_ACTIVE;
    end
  end

`ifdef TASK_MON_TIMEOUT_EN
  localparam int unsigned TimerW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYC - 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic              err_timeout_q, err_timeout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    timer_d       = timer_q;
    err_timeout_d = err_timeout_q & ~err_clr_i;
    if (start_i) begin
      timer_d = '0;
    end else if (state_q == MON_ACTIVE && !irq_i) begin
      // Hold at the limit; the task stays active so a late irq is still counted.
      if (timer_q == TimerMax) begin
        err_timeout_d = 1'b1;
      end else begin
        timer_d = timer_q + TimerW'(1);
      end
    end
  end

  assign err_timeout_o = err_timeout_q;
`else
  assign err_timeout_o = 1'b0;
`endif

  assign err_cfg_o   = err_cfg_q;
  assign err_proto_o = err_proto_q;
  assign done_cnt_o  = cnt_q;
  assign active_o    = (state_q == MON_ACTIVE);

endmodule

// File: rtl/task_cfg_monitor.sv
// Runtime config/protocol monitor for NUM_CH task engines; one task_ch_mon per channel.
// Optional timeout detection is enabled by defining TASK_MON_TIMEOUT_EN.
module task_cfg_monitor
  import task_mon_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned CFG_W       = PB_CFG_W,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*CFG_W-1:0] exp_cfg_i,
  input  logic [NUM_CH*CFG_W-1:0] ch_cfg_i,
  input  logic [NUM_CH-1:0]       ch_start_i,
  input  logic [NUM_CH-1:0]       ch_irq_i,
  input  logic                    err_clr_i,
  output logic [NUM_CH-1:0]       err_cfg_o,
  output logic [NUM_CH-1:0]       err_proto_o,
  output logic [NUM_CH-1:0]       err_timeout_o,
  output logic [NUM_CH*CNT_W-1:0] done_cnt_o,
  output logic [NUM_CH-1:0]       active_o,
  output logic                    any_err_o
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    task_ch_mon #(
      .CFG_W       (CFG_W),
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ch_mon (
      .clk           (clk),
      .reset         (reset),
      .exp_cfg_i     (exp_cfg_i[k*CFG_W +: CFG_W]),
      .ch_cfg_i      (ch_cfg_i[k*CFG_W +: CFG_W]),
      .start_i       (ch_start_i[k]),
      .irq_i         (ch_irq_i[k]),
      .err_clr_i     (err_clr_i),
      .err_cfg_o     (err_cfg_o[k]),
      .err_proto_o   (err_proto_o[k]),
      .err_timeout_o (err_timeout_o[k]),
      .done_cnt_o    (done_cnt_o[k*CNT_W +: CNT_W]),
      .active_o      (active_o[k])
    );
  end

  // err_timeout_o is constant zero when timers are not built.
  assign any_err_o = (|err_cfg_o) | (|err_proto_o) | (|err_timeout_o);

endmodule

// File: tb/tb_task_cfg_monitor.sv
// Self-checking bench for task_cfg_monitor: vector table, directed corner sequences, random vs model.
`timescale 1ns/1ps
module tb_task_cfg_monitor;
  import task_mon_pkg::*;

  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned CFG_W       = PB_CFG_W;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int          CntMax      = (1 << CNT_W) - 1;
`ifdef TASK_MON_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH*CFG_W-1:0] exp_cfg, ch_cfg;
  logic [NUM_CH-1:0]       ch_start, ch_irq;
  logic                    err_clr;
  logic [NUM_CH-1:0]       err_cfg, err_proto, err_timeout, active;
  logic [NUM_CH*CNT_W-1:0] done_cnt;
  logic                    any_err;

  always #5 clk = ~clk;

  task_cfg_monitor #(
    .NUM_CH      (NUM_CH),
    .CFG_W       (CFG_W),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .exp_cfg_i     (exp_cfg),
    .ch_cfg_i      (ch_cfg),
    .ch_start_i    (ch_start),
    .ch_irq_i      (ch_irq),
    .err_clr_i     (err_clr),
    .err_cfg_o     (err_cfg),
    .err_proto_o   (err_proto),
    .err_timeout_o (err_timeout),
    .done_cnt_o    (done_cnt),
    .active_o      (active),
    .any_err_o     (any_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic pb_cfg_t base_cfg(input int k);
    pb_cfg_t c;
    c          = '0;
    c.addr_in  = 32'h1000_0000 + 32'(k);
    c.byte_cnt = 4'h7;
    c.pkt_type = 4'h2;
    c.crc_en   = 1'b1;
    c.crc_val  = 8'hA5;
    c.sop_val  = 3'(k);
    c.addr_out = 32'h2000_0000 + 32'(k);
    return c;
  endfunction

  task automatic set_ch(input int k, input pb_cfg_t c);
    ch_cfg[k*CFG_W +: CFG_W] = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ch_start = '0;
    ch_irq   = '0;
    err_clr  = 1'b0;
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    ch_start = '0;
    ch_irq   = '0;
    err_clr  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_cfg[k*CFG_W +: CFG_W] = base_cfg(k);
      set_ch(k, base_cfg(k));
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  start;
    logic [2:0]  irq;
    logic [2:0]  bad;     // channel drives byte_cnt 5 instead of the expected 7
    logic        clr;
    logic [2:0]  act;
    logic [2:0]  ecfg;
    logic [2:0]  eproto;
    logic [11:0] done;
  } vec_t;

  vec_t tbl [15];

  // ---------------- reference model ----------------
  bit               m_act   [NUM_CH];
  logic [CFG_W-1:0] m_snap  [NUM_CH];
  int               m_age   [NUM_CH];
  int               m_cnt   [NUM_CH];
  bit               m_ecfg  [NUM_CH];
  bit               m_eprot [NUM_CH];
  bit               m_eto   [NUM_CH];

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_act[k] = 0; m_snap[k] = '0; m_age[k] = 0; m_cnt[k] = 0;
      m_ecfg[k] = 0; m_eprot[k] = 0; m_eto[k] = 0;
    end
  endtask

  // Applies this cycle's inputs to the model state as the task lifecycle rules describe.
  task automatic model_step();
    for (int k = 0; k < NUM_CH; k++) begin
      logic [CFG_W-1:0] cur, expv;
      bit s, i, set_c, set_p, set_t;
      cur   = ch_cfg[k*CFG_W +: CFG_W];
      expv  = exp_cfg[k*CFG_W +: CFG_W];
      s     = ch_start[k];
      i     = ch_irq[k];
      set_c = 0; set_p = 0; set_t = 0;
      if (m_act[k]) begin
        if (!s && cur != m_snap[k]) set_c = 1;
        if (i) m_cnt[k] = (m_cnt[k] < CntMax) ? m_cnt[k] + 1 : CntMax;
        if (s && !i) set_p = 1;
        if (!s && i) m_act[k] = 0;
        if (!s && !i && ToEn) begin
          if (m_age[k] >= int'(TIMEOUT_CYC) - 1) set_t = 1;
          else m_age[k]++;
        end
      end else if (i) begin
        set_p = 1;
      end
      if (s) begin
        if (cur != expv) set_c = 1;
        m_snap[k] = cur;
        m_age[k]  = 0;
        m_act[k]  = 1;
      end
      m_ecfg[k]  = (m_ecfg[k]  && !err_clr) || set_c;
      m_eprot[k] = (m_eprot[k] && !err_clr) || set_p;
      m_eto[k]   = (m_eto[k]   && !err_clr) || set_t;
    end
  endtask

  task automatic compare_model();
    logic [NUM_CH-1:0]       e_c, e_p, e_t, e_a;
    logic [NUM_CH*CNT_W-1:0] e_d;
    for (int k = 0; k < NUM_CH; k++) begin
      e_c[k] = m_ecfg[k];
      e_p[k] = m_eprot[k];
      e_t[k] = m_eto[k];
      e_a[k] = m_act[k];
      e_d[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
    end
    check("rnd err_cfg", 64'(err_cfg), 64'(e_c));
    check("rnd err_proto", 64'(err_proto), 64'(e_p));
    check("rnd err_timeout", 64'(err_timeout), 64'(e_t));
    check("rnd active", 64'(active), 64'(e_a));
    check("rnd done_cnt", 64'(done_cnt), 64'(e_d));
    check("rnd any_err", 64'(any_err), 64'((|e_c) | (|e_p) | (|e_t)));
  endtask

  initial begin
    pb_cfg_t c;
    //          start   irq     bad     clr   act     ecfg    eproto  done
    tbl[0]  = '{3'b001, 3'b000, 3'b000, 1'b0, 3'b001, 3'b000, 3'b000, 12'h000};
    tbl[1]  = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b001, 3'b000, 3'b000, 12'h000};
    tbl[2]  = '{3'b000, 3'b001, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 12'h001};
    tbl[3]  = '{3'b010, 3'b000, 3'b010, 1'b0, 3'b010, 3'b010, 3'b000, 12'h001};
    tbl[4]  = '{3'b000, 3'b000, 3'b010, 1'b1, 3'b010, 3'b000, 3'b000, 12'h001};
    tbl[5]  = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b010, 3'b010, 3'b000, 12'h001};
    tbl[6]  = '{3'b000, 3'b010, 3'b000, 1'b1, 3'b000, 3'b010, 3'b000, 12'h011};
    tbl[7]  = '{3'b000, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 12'h011};
    tbl[8]  = '{3'b000, 3'b100, 3'b000, 1'b0, 3'b000, 3'b000, 3'b100, 12'h011};
    tbl[9]  = '{3'b100, 3'b000, 3'b000, 1'b0, 3'b100, 3'b000, 3'b100, 12'h011};
    tbl[10] = '{3'b000, 3'b000, 3'b000, 1'b1, 3'b100, 3'b000, 3'b000, 12'h011};
    tbl[11] = '{3'b100, 3'b000, 3'b000, 1'b0, 3'b100, 3'b000, 3'b100, 12'h011};
    tbl[12] = '{3'b100, 3'b100, 3'b000, 1'b1, 3'b100, 3'b000, 3'b000, 12'h111};
    tbl[13] = '{3'b000, 3'b100, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 12'h211};
    tbl[14] = '{3'b001, 3'b001, 3'b000, 1'b0, 3'b001, 3'b000, 3'b001, 12'h211};

    reset_dut();
    check("reset err_cfg", 64'(err_cfg), 64'(0));
    check("reset err_proto", 64'(err_proto), 64'(0));
    check("reset active", 64'(active), 64'(0));
    check("reset done_cnt", 64'(done_cnt), 64'(0));
    check("reset any_err", 64'(any_err), 64'(0));

    foreach (tbl[r]) begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = base_cfg(k);
        if (tbl[r].bad[k]) c.byte_cnt = 4'h5;
        set_ch(k, c);
      end
      ch_start = tbl[r].start;
      ch_irq   = tbl[r].irq;
      err_clr  = tbl[r].clr;
      tick();
      check($sformatf("tbl%0d active", r), 64'(active), 64'(tbl[r].act));
      check($sformatf("tbl%0d err_cfg", r), 64'(err_cfg), 64'(tbl[r].ecfg));
      check($sformatf("tbl%0d err_proto", r), 64'(err_proto), 64'(tbl[r].eproto));
      check($sformatf("tbl%0d done_cnt", r), 64'(done_cnt), 64'(tbl[r].done));
      check($sformatf("tbl%0d any_err", r), 64'(any_err),
            64'((|tbl[r].ecfg) | (|tbl[r].eproto)));
    end

    // Clean task on channel 0: active for exactly 10 cycles, then counted.
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) ch_start = 3'b001;
      tick();
      check($sformatf("clean active c%0d", i), 64'(active), 64'(3'b001));
    end
    ch_irq = 3'b001;
    tick();
    check("clean active end", 64'(active), 64'(0));
    check("clean done_cnt", 64'(done_cnt), 64'(12'h001));
    check("clean any_err", 64'(any_err), 64'(0));

    // Back-to-back start+irq, then asynchronous reset mid-task.
    ch_start = 3'b001;
    tick();
    ch_start = 3'b001;
    ch_irq   = 3'b001;
    tick();
    check("b2b done_cnt", 64'(done_cnt), 64'(12'h002));
    check("b2b active", 64'(active), 64'(3'b001));
    check("b2b err_proto", 64'(err_proto), 64'(0));
    #1 reset = 1'b1;
    #1;
    check("async rst active", 64'(active), 64'(0));
    check("async rst done_cnt", 64'(done_cnt), 64'(0));
    check("async rst any_err", 64'(any_err), 64'(0));
    #1 reset = 1'b0;
    ch_irq = 3'b001;
    tick();
    check("post rst irq err_proto", 64'(err_proto), 64'(3'b001));
    check("post rst irq active", 64'(active), 64'(0));

    // crc_val change while active on channel 2, then idle irq on channel 0.
    reset_dut();
    ch_start = 3'b100;
    tick();
    c = base_cfg(2);
    c.crc_val = 8'h5A;
    set_ch(2, c);
    tick();
    check("crc change err_cfg", 64'(err_cfg), 64'(3'b100));
    set_ch(2, base_cfg(2));
    ch_irq = 3'b001;
    tick();
    check("idle irq err_proto", 64'(err_proto), 64'(3'b001));
    check("idle irq err_cfg sticky", 64'(err_cfg), 64'(3'b100));
    check("idle irq any_err", 64'(any_err), 64'(1));

    // Timeout: limit reached on the 16th idle active cycle; late irq still counts.
    reset_dut();
    ch_start = 3'b001;
    tick();
    repeat (15) tick();
    check("timeout early", 64'(err_timeout), 64'(0));
    tick();
    check("timeout flag", 64'(err_timeout), 64'({2'b00, ToEn}));
    check("timeout any_err", 64'(any_err), 64'(ToEn));
    check("timeout still active", 64'(active), 64'(3'b001));
    ch_irq = 3'b001;
    tick();
    check("late irq done_cnt", 64'(done_cnt), 64'(12'h001));
    check("late irq active", 64'(active), 64'(0));
    check("late irq err_proto", 64'(err_proto), 64'(0));

    // Counter saturation on channel 1.
    reset_dut();
    repeat (CntMax + 2) begin
      ch_start = 3'b010;
      tick();
      ch_irq = 3'b010;
      tick();
    end
    check("saturate done_cnt", 64'(done_cnt), 64'(12'h0F0));

    // Randomized run against the model.
    reset_dut();
    model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      exp_cfg[k*CFG_W +: CFG_W] = {$urandom, $urandom, $urandom};
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        logic [CFG_W-1:0] v;
        v = exp_cfg[k*CFG_W +: CFG_W];
        if ($urandom_range(0, 11) == 0) v[$urandom_range(0, CFG_W-1)] ^= 1'b1;
        ch_cfg[k*CFG_W +: CFG_W] = v;
        if (k == 2) begin
          ch_start[k] = ($urandom_range(0, 29) == 0);
          ch_irq[k]   = ($urandom_range(0, 39) == 0);
        end else begin
          ch_start[k] = ($urandom_range(0, 5) == 0);
          ch_irq[k]   = ($urandom_range(0, 4) == 0);
        end
      end
      err_clr = ($urandom_range(0, 19) == 0);
      model_step();
      tick();
      compare_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
